uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised serial receiver for the Tang Nano UART path. It supports 5-8 data bits, optional odd/even parity and false-start rejection. Each received character, with its error flags, is written into a show-ahead FIFO. Front-end logic drains the FIFO with a pop strobe instead of clearing a single-byte ready flag.

Parameters:
CLK_FRQ, 27_000_000, system clock frequency in Hz
BAUD_RATE, 115200, serial baud rate; CYCLE = CLK_FRQ/BAUD_RATE, legal range 4..65535
DATA_BITS, 8, data bits per character, legal range 5..8, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous assert, active-low
rx_pin  in  1  serial input, idle high, asynchronous to clk
rx_pop  in  1  remove head entry; ignored when rx_valid=0
rx_valid  out  1  FIFO not empty
rx_data  out  8  head entry data, zero-extended above DATA_BITS
rx_perr  out  1  head entry parity error (always 0 when PARITY=0)
rx_ferr  out  1  head entry framing error (stop bit sampled 0)
rx_count  out  FIFO_AW+1  current number of entries
rx_overrun  out  1  sticky: a character was dropped because the FIFO was full
rx_clr_ovr  in  1  clears rx_overrun

Behaviour:
- Reset: asynchronous on reset_n low; every register is cleared while reset is held.
  - State = IDLE; FIFO empty; rx_valid=0, rx_count=0, rx_overrun=0, rx_data=0, rx_perr=0, rx_ferr=0.
  - Synchroniser flops reset to 1, so no false start is taken at reset release.
  - Reset mid-character discards the partial character.
- Input path: rx_pin goes through a 2-flop synchroniser (rx_s). The FSM sees only rx_s.
- Bit counter: 16-bit cycle_cnt, cleared on every state change.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START.
  - START: at cycle_cnt==CYCLE/2-1, sample rx_s. If 1, it is a false start -> IDLE with no write. If 0 -> DATA.
  - DATA: sample rx_s into shift bit bit_cnt at each cycle_cnt==CYCLE-1, then reset cycle_cnt. After bit DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
  - PARITY: sample at cycle_cnt==CYCLE-1.
    - Odd parity: perr = ~^{data, p}.
    - Even parity: perr = ^{data, p}.
    - Then -> STOP.
  - STOP: sample at cycle_cnt==CYCLE-1 (mid stop bit). ferr = ~rx_s. On this same edge, push {perr, ferr, data} into the FIFO. Then:
    - ferr=1 and data all zero (break) -> WAIT_HIGH.
    - otherwise -> IDLE, so a start edge half a bit later is caught.
  - WAIT_HIGH: remain until rx_s==1, then -> IDLE. A held-low line produces exactly one break entry.
- FIFO behaviour:
  - Show-ahead: rx_data/rx_perr/rx_ferr are valid whenever rx_valid=1.
  - A pushed entry is visible (rx_valid, rx_count) on the cycle after the push edge.
  - A pop removes the head; the next entry (or rx_valid=0) appears on the following cycle.
- Simultaneous push and pop:
  - Not full: rx_count is unchanged.
  - Full: the pop frees a slot, the push is accepted and rx_count stays at depth; no overrun.
- Push while full without pop: the character is dropped and rx_overrun is set. FIFO contents and rx_count are unchanged.
- rx_overrun:
  - rx_clr_ovr clears it on the next edge.
  - If rx_clr_ovr and a new overrun occur in the same cycle, set wins.
- Pointers: FIFO_AW-bit read/write pointers wrap modulo depth. rx_count holds values 0..depth inclusive.
- rx_pop while empty: no effect, no underflow.

Test Plan:
- Setup: CLK_FRQ=1_600_000, BAUD_RATE=100_000 (CYCLE=16), DATA_BITS=8, PARITY=0, FIFO_AW=2.
  - Send 0x55 then 0xA3, no pop -> rx_count=2; rx_data=0x55 with perr=0, ferr=0; pop -> rx_data=0xA3, rx_count=1; pop -> rx_valid=0.
- False start: rx_pin low for 5 clks then high -> FSM returns to IDLE; rx_count stays 0; following 0x3C is received intact.
- PARITY=1 (odd):
  - Send 0x07 with parity bit 0 -> entry 0x07, perr=0.
  - Send 0x07 with parity bit 1 -> perr=1, data still 0x07.
- Framing and break:
  - Send 0x81 with stop bit 0 -> ferr=1, data=0x81, state returns to IDLE.
  - Hold rx_pin low for 40 bit-times -> exactly one entry (0x00, ferr=1); no further entries until rx_pin returns high.
- Overrun:
  - Send 5 characters 0x10..0x14 without popping -> rx_count=4, rx_overrun=1, FIFO holds 0x10..0x13.
  - Assert rx_clr_ovr -> rx_overrun=0.
  - Pop on the exact stop-sample edge of a 5th character -> no overrun, rx_count remains 4.
- DATA_BITS=5: send 0x1F -> rx_data=0x1F with bits 7:5 = 0.
- Reset mid-character: assert reset_n=0 during bit 3 of 0xFF -> outputs cleared immediately; no entry after release; next byte received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, parity and a show-ahead FIFO.
// Each character lands in the FIFO with its parity/framing error flags.
module uart_rx_fifo #(
  parameter int CLK_FRQ   = 27_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int FIFO_AW   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_pin,
  input  logic             rx_pop,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic [FIFO_AW:0] rx_count,
  output logic             rx_overrun,
  input  logic             rx_clr_ovr
);

  localparam int CYCLE = CLK_FRQ / BAUD_RATE;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [15:0] CYC_M1  = 16'(CYCLE - 1);
  localparam logic [15:0] HALF_M1 = 16'(CYCLE / 2 - 1);
  localparam logic [2:0]  LAST    = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        rx_m_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        perr_q, perr_d;
  logic        push, ferr;

  logic [9:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               ovr_q;
  logic               full, do_pop, do_push, drop;
  logic [9:0]         head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      rx_m_q  <= rx_pin;
      rx_s_q  <= rx_m_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    data_d  = data_q;
    perr_d  = perr_q;
    push    = 1'b0;
    ferr    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          data_d  = '0;
          perr_d  = 1'b0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CYC_M1) begin
          cnt_d         = '0;
          data_d[bit_q] = rx_s_q;
          bit_d         = bit_q + 3'd1;
          if (bit_q == LAST)
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (cnt_q == CYC_M1) begin
          cnt_d   = '0;
          perr_d  = (PARITY == 1) ? ~^{data_q, rx_s_q}
                                  : ^{data_q, rx_s_q};
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CYC_M1) begin
          cnt_d   = '0;
          ferr    = ~rx_s_q;
          push    = 1'b1;
          // a break holds the line low; wait for idle before re-arming
          state_d = (ferr && data_q == 8'd0) ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign full    = count_q[FIFO_AW];
  assign do_pop  = rx_pop && (count_q != '0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= {perr_q, ferr, data_q};
        wptr_q        <= wptr_q + FIFO_AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + FIFO_AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop)            ovr_q <= 1'b1;
      else if (rx_clr_ovr) ovr_q <= 1'b0;
    end
  end

  assign head       = mem_q[rptr_q];
  assign rx_valid   = (count_q != '0);
  assign rx_data    = rx_valid ? head[7:0] : 8'd0;
  assign rx_ferr    = rx_valid & head[8];
  assign rx_perr    = rx_valid & head[9];
  assign rx_count   = count_q;
  assign rx_overrun = ovr_q;

endmodule
